// File: rtl/mips_isa_pkg.sv
// MIPS ISA definitions shared by the encoder, its interface and the bench:
// instruction kinds, opcode/funct values and field-packing helpers.
package mips_isa_pkg;

   typedef enum logic [3:0] {
      KindAdd, KindSub, KindAnd, KindOr, KindNor, KindSlt, KindXor, KindAddi,
      KindLw, KindSw, KindBeq, KindBne, KindJ, KindAndi, KindOri, KindXori
   } instr_kind_e;

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpBne   = 6'b000101;
   localparam logic [5:0] OpJ     = 6'b000010;
   localparam logic [5:0] OpAndi  = 6'b001100;
   localparam logic [5:0] OpOri   = 6'b001101;
   localparam logic [5:0] OpXori  = 6'b001110;

   localparam logic [5:0] FunctAdd = 6'b100000;
   localparam logic [5:0] FunctSub = 6'b100010;
   localparam logic [5:0] FunctAnd = 6'b100100;
   localparam logic [5:0] FunctOr  = 6'b100101;
   localparam logic [5:0] FunctNor = 6'b100111;
   localparam logic [5:0] FunctSlt = 6'b101010;
   localparam logic [5:0] FunctXor = 6'b100110;

   localparam logic [31:0] NopWord = 32'h0000_0000;

   function automatic logic [31:0] r_word(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                          logic [5:0] funct);
      return {OpRtype, rs, rt, rd, 5'b00000, funct};
   endfunction

   function automatic logic [31:0] i_word(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                          logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

endpackage

// File: rtl/mips_instr_encoder_if.sv
// Record stream into the encoder: symbolic instruction fields plus valid/ready.
interface mips_instr_encoder_if;
   import mips_isa_pkg::*;

   logic        in_valid;
   logic        in_ready;
   instr_kind_e in_kind;
   logic [4:0]  in_rs;
   logic [4:0]  in_rt;
   logic [4:0]  in_rd;
   logic [15:0] in_imm;
   logic [25:0] in_target;
   logic        in_last;

   modport master (
      output in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target, in_last,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target, in_last,
      output in_ready
   );

endinterface

// File: rtl/mips_instr_encode.sv
// Purely combinational assembly of one symbolic record into a 32-bit MIPS word.
// Fields a kind does not use are ignored.
module mips_instr_encode
   import mips_isa_pkg::*;
(
   input  instr_kind_e kind_i,
   input  logic [4:0]  rs_i,
   input  logic [4:0]  rt_i,
   input  logic [4:0]  rd_i,
   input  logic [15:0] imm_i,
   input  logic [25:0] target_i,
   output logic [31:0] word_o
);

   // Select the instruction format and opcode/funct for the kind.
   always_comb begin
      word_o = NopWord;
      case (kind_i)
         KindAdd:  word_o = r_word(rs_i, rt_i, rd_i, FunctAdd);
         KindSub:  word_o = r_word(rs_i, rt_i, rd_i, FunctSub);
         KindAnd:  word_o = r_word(rs_i, rt_i, rd_i, FunctAnd);
         KindOr:   word_o = r_word(rs_i, rt_i, rd_i, FunctOr);
         KindNor:  word_o = r_word(rs_i, rt_i, rd_i, FunctNor);
         KindSlt:  word_o = r_word(rs_i, rt_i, rd_i, FunctSlt);
         KindXor:  word_o = r_word(rs_i, rt_i, rd_i, FunctXor);
         KindAddi: word_o = i_word(OpAddi, rs_i, rt_i, imm_i);
         KindLw:   word_o = i_word(OpLw, rs_i, rt_i, imm_i);
         KindSw:   word_o = i_word(OpSw, rs_i, rt_i, imm_i);
         KindBeq:  word_o = i_word(OpBeq, rs_i, rt_i, imm_i);
         KindBne:  word_o = i_word(OpBne, rs_i, rt_i, imm_i);
         KindJ:    word_o = {OpJ, target_i};
         KindAndi: word_o = i_word(OpAndi, rs_i, rt_i, imm_i);
         KindOri:  word_o = i_word(OpOri, rs_i, rt_i, imm_i);
         KindXori: word_o = i_word(OpXori, rs_i, rt_i, imm_i);
         default:  word_o = NopWord;
      endcase
   end

endmodule

// File: rtl/mips_instr_encoder.sv
// Program loader: accepts instruction records, encodes them and writes them to
// consecutive instruction-memory words starting at 0, one word per two cycles.
// Build option ZERO_FILL_EN: after the last record, zero the remaining words.
module mips_instr_encoder
   import mips_isa_pkg::*;
#(
   parameter int unsigned ADDR_W = 6
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                start_i,
   mips_instr_encoder_if.slave in_if,
   output logic                mem_we_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [31:0]         mem_wdata_o,
   output logic [ADDR_W:0]     count_o,
   output logic                done_o,
   output logic                full_o
);

   typedef enum logic [2:0] {
      StIdle,
      StAccept,
      StWrite,
`ifdef ZERO_FILL_EN
      StFill,
`endif
      StDone,
      StFull
   } state_e;

   localparam logic [ADDR_W-1:0] PtrMax = '1;
   localparam logic [ADDR_W-1:0] PtrOne = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   CntOne = {{ADDR_W{1'b0}}, 1'b1};

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic                last_q, last_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [31:0]         enc_word;

   mips_instr_encode u_encode (
      .kind_i   (in_if.in_kind),
      .rs_i     (in_if.in_rs),
      .rt_i     (in_if.in_rt),
      .rd_i     (in_if.in_rd),
      .imm_i    (in_if.in_imm),
      .target_i (in_if.in_target),
      .word_o   (enc_word)
   );

   // Next-state: session control, pointer/count bookkeeping, write-port staging.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      count_d = count_q;
      last_d  = last_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         StIdle, StDone, StFull: begin
            if (start_i) begin
               state_d = StAccept;
               ptr_d   = '0;
               count_d = '0;
            end
         end
         StAccept: begin
            // Address and data are staged here so they hold once the strobe drops.
            if (in_if.in_valid) begin
               addr_d  = ptr_q;
               wdata_d = enc_word;
               last_d  = in_if.in_last;
               state_d = StWrite;
            end
         end
         StWrite: begin
            count_d = count_q + CntOne;
            if (ptr_q != PtrMax) ptr_d = ptr_q + PtrOne;
            if (last_q) begin
`ifdef ZERO_FILL_EN
               if (ptr_q != PtrMax) begin
                  state_d = StFill;
                  addr_d  = ptr_q + PtrOne;
                  wdata_d = NopWord;
               end else begin
                  state_d = StDone;
               end
`else
               state_d = StDone;
`endif
            end else if (ptr_q == PtrMax) begin
               state_d = StFull;
            end else begin
               state_d = StAccept;
            end
         end
`ifdef ZERO_FILL_EN
         StFill: begin
            count_d = count_q + CntOne;
            if (ptr_q == PtrMax) begin
               state_d = StDone;
            end else begin
               ptr_d  = ptr_q + PtrOne;
               addr_d = ptr_q + PtrOne;
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         count_q <= '0;
         last_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         count_q <= count_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // Moore outputs decoded from the state.
   always_comb begin
      in_if.in_ready = (state_q == StAccept);
`ifdef ZERO_FILL_EN
      mem_we_o       = (state_q == StWrite) || (state_q == StFill);
`else
      mem_we_o       = (state_q == StWrite);
`endif
      done_o         = (state_q == StDone);
      full_o         = (state_q == StFull);
      mem_addr_o     = addr_q;
      mem_wdata_o    = wdata_q;
      count_o        = count_q;
   end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Bench for mips_instr_encoder: a 64-word and a 4-word instance share one record
// stream; only the instance with an open session accepts records.
module tb_mips_instr_encoder;
   import mips_isa_pkg::*;

   localparam int unsigned AW6 = 6;
   localparam int unsigned AW2 = 2;
   localparam longint unsigned P26 = 64'd67108864;
   localparam longint unsigned P21 = 64'd2097152;
   localparam longint unsigned P16 = 64'd65536;
   localparam longint unsigned P11 = 64'd2048;

   typedef struct {
      int unsigned kind;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [15:0] imm;
      logic [25:0] target;
      logic        last;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      int unsigned addr;
      logic [31:0] data;
      int unsigned cyc;
   } wr_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset6, start6, reset2, start2;
   mips_instr_encoder_if if6 ();
   mips_instr_encoder_if if2 ();

   logic           mem_we6, done6, full6;
   logic [AW6-1:0] mem_addr6;
   logic [31:0]    wdata6;
   logic [AW6:0]   count6;
   logic           mem_we2, done2, full2;
   logic [AW2-1:0] mem_addr2;
   logic [31:0]    wdata2;
   logic [AW2:0]   count2;

   mips_instr_encoder #(.ADDR_W(AW6)) dut6 (
      .clk_i(clk), .reset_i(reset6), .start_i(start6), .in_if(if6),
      .mem_we_o(mem_we6), .mem_addr_o(mem_addr6), .mem_wdata_o(wdata6),
      .count_o(count6), .done_o(done6), .full_o(full6)
   );

   mips_instr_encoder #(.ADDR_W(AW2)) dut2 (
      .clk_i(clk), .reset_i(reset2), .start_i(start2), .in_if(if2),
      .mem_we_o(mem_we2), .mem_addr_o(mem_addr2), .mem_wdata_o(wdata2),
      .count_o(count2), .done_o(done2), .full_o(full2)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int unsigned cyc = 0;
   wr_t  log6[$];
   wr_t  log2[$];
   vec_t cur[$];
   vec_t tab[13];

   always @(posedge clk) cyc <= cyc + 1;

   // Write monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (mem_we6 === 1'b1) log6.push_back('{int'(mem_addr6), wdata6, cyc});
      if (mem_we2 === 1'b1) log2.push_back('{int'(mem_addr2), wdata2, cyc});
   end

   function automatic void check(input string name, input logic [63:0] act,
                                 input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   // Reference encoding from the ISA field layout, by arithmetic.
   function automatic logic [31:0] ref_encode(input vec_t v);
      int unsigned funct_tab[7];
      int unsigned op_tab[16];
      longint unsigned rs, rt, rd, imm, tgt, w;
      funct_tab = '{32, 34, 36, 37, 39, 42, 38};
      op_tab    = '{0, 0, 0, 0, 0, 0, 0, 8, 35, 43, 4, 5, 2, 12, 13, 14};
      rs = v.rs; rt = v.rt; rd = v.rd; imm = v.imm; tgt = v.target;
      if (v.kind < 7)       w = rs * P21 + rt * P16 + rd * P11 + funct_tab[v.kind];
      else if (v.kind == 12) w = 2 * P26 + tgt;
      else if (v.kind < 16) w = op_tab[v.kind] * P26 + rs * P21 + rt * P16 + imm;
      else                  w = 0;
      return w[31:0];
   endfunction

   function automatic vec_t rand_vec(input logic last);
      vec_t v;
      v.kind   = $urandom_range(0, 15);
      v.rs     = 5'($urandom);
      v.rt     = 5'($urandom);
      v.rd     = 5'($urandom);
      v.imm    = 16'($urandom);
      v.target = 26'($urandom);
      v.last   = last;
      v.exp    = 32'h0;
      return v;
   endfunction

   function automatic logic sess_end(input int sel);
      return (sel == 6) ? (done6 | full6) : (done2 | full2);
   endfunction

   task automatic drive(input vec_t v, input logic valid);
      if6.in_kind = instr_kind_e'(v.kind[3:0]); if2.in_kind = instr_kind_e'(v.kind[3:0]);
      if6.in_rs = v.rs; if2.in_rs = v.rs;
      if6.in_rt = v.rt; if2.in_rt = v.rt;
      if6.in_rd = v.rd; if2.in_rd = v.rd;
      if6.in_imm = v.imm; if2.in_imm = v.imm;
      if6.in_target = v.target; if2.in_target = v.target;
      if6.in_last = v.last; if2.in_last = v.last;
      if6.in_valid = valid; if2.in_valid = valid;
   endtask

   // Offer a record; returns at the negedge after acceptance, or gives up.
   task automatic send(input int sel, input vec_t v, output bit ok);
      drive(v, 1'b1);
      ok = 1'b0;
      for (int t = 0; t < 20; t++) begin
         if (((sel == 6) ? if6.in_ready : if2.in_ready) === 1'b1) begin
            @(negedge clk);
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic pulse_start(input int sel);
      if (sel == 6) start6 = 1'b1; else start2 = 1'b1;
      @(negedge clk);
      start6 = 1'b0; start2 = 1'b0;
   endtask

   task automatic wait_end(input int sel);
      for (int t = 0; t < 300; t++) begin
         if (sess_end(sel)) break;
         @(negedge clk);
      end
   endtask

   // Compare the logged writes and final status against the records in cur.
   task automatic check_session(input int sel, input bit use_tab);
      wr_t lg[$];
      int unsigned cap, n_exp;
      logic [31:0] ew, last_w;
      if (sel == 6) begin lg = log6; cap = 64; end else begin lg = log2; cap = 4; end
      n_exp = cur.size();
`ifdef ZERO_FILL_EN
      n_exp = cap;
`endif
      check("write_count", lg.size(), n_exp);
      last_w = 32'h0;
      for (int i = 0; i < lg.size() && i < n_exp; i++) begin
         if (i < cur.size()) ew = use_tab ? cur[i].exp : ref_encode(cur[i]);
         else ew = 32'h0;
         last_w = ew;
         check("wr_addr", lg[i].addr, i);
         check("wr_data", lg[i].data, ew);
         if (i >= cur.size()) check("fill_cycle", lg[i].cyc, lg[i-1].cyc + 1);
      end
      if (sel == 6) begin
         check("count", count6, n_exp);
         check("done", done6, 1);
         check("full", full6, 0);
         check("ready_idle", if6.in_ready, 0);
         check("we_idle", mem_we6, 0);
         check("addr_hold", mem_addr6, n_exp - 1);
         check("wdata_hold", wdata6, last_w);
      end else begin
         check("count", count2, n_exp);
         check("done", done2, 1);
         check("full", full2, 0);
         check("ready_idle", if2.in_ready, 0);
         check("addr_hold", mem_addr2, n_exp - 1);
      end
   endtask

   task automatic run_session(input int sel, input int max_gap, input bit use_tab);
      bit ok;
      if (sel == 6) log6.delete(); else log2.delete();
      pulse_start(sel);
      foreach (cur[i]) begin
         repeat ($urandom_range(0, max_gap)) begin
            drive(cur[i], 1'b0);
            @(negedge clk);
         end
         send(sel, cur[i], ok);
         check("accepted", ok, 1);
      end
      drive(cur[cur.size()-1], 1'b0);
      wait_end(sel);
      check_session(sel, use_tab);
   endtask

   task automatic load_tab(input int first, input int last_idx);
      cur.delete();
      for (int i = first; i <= last_idx; i++) begin
         cur.push_back(tab[i]);
         cur[cur.size()-1].last = (i == last_idx);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      vec_t v;
      // kind, rs, rt, rd, imm, target, last, expected word
      tab[0]  = '{0,  5'd1,  5'd2,  5'd3,  16'h0,    26'h0,       1'b0, 32'h00221820};
      tab[1]  = '{8,  5'd29, 5'd8,  5'd0,  16'h0004, 26'h0,       1'b0, 32'h8FA80004};
      tab[2]  = '{10, 5'd4,  5'd5,  5'd0,  16'hFFFF, 26'h0,       1'b0, 32'h1085FFFF};
      tab[3]  = '{12, 5'd0,  5'd0,  5'd0,  16'h0,    26'h0100000, 1'b0, 32'h08100000};
      tab[4]  = '{1,  5'd31, 5'd31, 5'd31, 16'h0,    26'h0,       1'b0, 32'h03FFF822};
      tab[5]  = '{7,  5'd0,  5'd1,  5'd7,  16'h1234, 26'h0,       1'b0, 32'h20011234};
      tab[6]  = '{9,  5'd2,  5'd3,  5'd0,  16'h0008, 26'h0,       1'b0, 32'hAC430008};
      tab[7]  = '{12, 5'd5,  5'd0,  5'd0,  16'h0,    26'h3FFFFFF, 1'b0, 32'h0BFFFFFF};
      tab[8]  = '{15, 5'd1,  5'd2,  5'd0,  16'hFFFF, 26'h0,       1'b0, 32'h3822FFFF};
      tab[9]  = '{4,  5'd1,  5'd2,  5'd3,  16'hFFFF, 26'h0,       1'b0, 32'h00221827};
      tab[10] = '{11, 5'd3,  5'd0,  5'd0,  16'h8000, 26'h0,       1'b0, 32'h14608000};
      tab[11] = '{5,  5'd8,  5'd9,  5'd10, 16'h0,    26'h0,       1'b0, 32'h0109502A};
      tab[12] = '{14, 5'd0,  5'd31, 5'd0,  16'h00FF, 26'h0,       1'b0, 32'h341F00FF};

      reset6 = 1'b1; reset2 = 1'b1; start6 = 1'b0; start2 = 1'b0;
      drive(tab[0], 1'b0);
      repeat (3) @(negedge clk);
      check("rst_we", {mem_we6, mem_we2}, 0);
      check("rst_addr", {mem_addr6, mem_addr2}, 0);
      check("rst_wdata", {wdata6, wdata2}, 0);
      check("rst_count", {count6, count2}, 0);
      check("rst_done_full", {done6, full6, done2, full2}, 0);
      check("rst_ready", {if6.in_ready, if2.in_ready}, 0);
      reset6 = 1'b0; reset2 = 1'b0;
      @(negedge clk);
      check("idle_ready", if6.in_ready, 0);

      // Directed table sessions; the last one keeps in_valid high throughout.
      load_tab(0, 0);  run_session(6, 0, 1'b1);
      load_tab(1, 3);  run_session(6, 2, 1'b1);
      load_tab(0, 12); run_session(6, 0, 1'b1);

      // start pulses during WRITE and ACCEPT must not restart the session.
      load_tab(4, 5);
      log6.delete();
      pulse_start(6);
      send(6, cur[0], ok);
      check("accepted", ok, 1);
      start6 = 1'b1;
      @(negedge clk);
      send(6, cur[1], ok);
      start6 = 1'b0;
      check("accepted", ok, 1);
      drive(cur[1], 1'b0);
      wait_end(6);
      check_session(6, 1'b1);

      // Reset during the WRITE cycle abandons the session.
      load_tab(6, 7);
      pulse_start(6);
      send(6, cur[0], ok);
      check("wr_cycle_we", mem_we6, 1);
      reset6 = 1'b1;
      drive(cur[0], 1'b0);
      @(negedge clk);
      reset6 = 1'b0;
      check("rst_wr_we", mem_we6, 0);
      check("rst_wr_count", count6, 0);
      check("rst_wr_ready", if6.in_ready, 0);
      check("rst_wr_done", done6, 0);
      load_tab(7, 7);  run_session(6, 1, 1'b1);

      // 4-word memory: five records without last fill it and the fifth is refused.
      cur.delete();
      log2.delete();
      pulse_start(2);
      for (int i = 0; i < 5; i++) begin
         v = rand_vec(1'b0);
         send(2, v, ok);
         check("full_accept", ok, (i < 4));
         if (ok) cur.push_back(v);
      end
      drive(v, 1'b0);
      check("full_writes", log2.size(), 4);
      for (int i = 0; i < log2.size() && i < 4; i++) begin
         check("full_addr", log2[i].addr, i);
         check("full_data", log2[i].data, ref_encode(cur[i]));
      end
      check("full_flag", full2, 1);
      check("full_done", done2, 0);
      check("full_count", count2, 4);
      check("full_ready", if2.in_ready, 0);

      // Single record (fill case when enabled), then last record at the top address.
      cur.delete(); cur.push_back(rand_vec(1'b1)); run_session(2, 1, 1'b0);
      cur.delete();
      for (int i = 0; i < 4; i++) cur.push_back(rand_vec(i == 3));
      run_session(2, 0, 1'b0);

      // Randomized sessions against the reference model.
      for (int s = 0; s < 25; s++) begin
         int unsigned n;
         n = $urandom_range(1, 12);
         cur.delete();
         for (int i = 0; i < n; i++) cur.push_back(rand_vec(i == n - 1));
         run_session(6, 3, 1'b0);
      end
      for (int s = 0; s < 6; s++) begin
         int unsigned n;
         n = $urandom_range(1, 4);
         cur.delete();
         for (int i = 0; i < n; i++) cur.push_back(rand_vec(i == n - 1));
         run_session(2, 2, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
